// File: rtl/lapido_run_ctrl_pkg.sv
// Shared definitions for the lapido execution sequencer: state encoding,
// default widths and the drain-counter sizing helper.
package lapido_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RC_IDLE   = 2'd0,
        RC_RUN    = 2'd1,
        RC_DRAIN  = 2'd2,
        RC_HALTED = 2'd3
    } rc_state_t;

    localparam int RC_PC_WIDTH     = 32;
    localparam int RC_CNT_WIDTH    = 32;
    localparam int RC_DRAIN_CYCLES = 3;

    // Bits needed to hold the drain load value (at least one bit).
    function automatic int rc_drain_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lapido_run_ctrl_if.sv
// Control/observation bundle between the sequencer and whoever drives it
// (the core wrapper or a bench). Clock and reset stay outside the bundle.
interface lapido_run_ctrl_if
    import lapido_run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH  = RC_PC_WIDTH,
    parameter int CNT_WIDTH = RC_CNT_WIDTH
);
    logic                 start;
    logic                 abort;
    logic                 step_mode;
    logic                 step;
    logic                 id_is_jump;
    logic [PC_WIDTH-1:0]  id_jump_addr;
    logic [PC_WIDTH-1:0]  if_pc;
    logic                 core_en;
    logic                 busy;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, abort, step_mode, step, id_is_jump, id_jump_addr, if_pc,
        input  core_en, busy, halted, cycle_count
    );

    modport slave (
        input  start, abort, step_mode, step, id_is_jump, id_jump_addr, if_pc,
        output core_en, busy, halted, cycle_count
    );
endinterface

// File: rtl/lapido_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module lapido_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; stop counting once every bit is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lapido_run_ctrl.sv
// Execution sequencer for lapido_top: gates the core clock-enable in
// free-run or single-step, spots the jump-to-self halt idiom, drains the
// pipeline for a fixed number of cycles and then parks the core.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RC_IDLE   | core parked, waiting for start (after reset or abort)
// RC_RUN    | executing; core_en free-running or one cycle per step
// RC_DRAIN  | halt seen; core_en forced high while the pipe empties
// RC_HALTED | drain done, halted flag up, start relaunches
module lapido_run_ctrl
    import lapido_run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH     = RC_PC_WIDTH,
    parameter int CNT_WIDTH    = RC_CNT_WIDTH,
    parameter int DRAIN_CYCLES = RC_DRAIN_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    lapido_run_ctrl_if.slave   bus
);

    localparam int            DW         = rc_drain_width(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    rc_state_t           state;
    logic [DW-1:0]       drain_cnt;
    logic                core_en_q;
    logic                busy_q;
    logic                halted_q;
    logic [PC_WIDTH-1:0] halt_target;
    logic                halt_hit;
    logic                cnt_clear;

    // Jump-to-self: ID target equals IF pc minus one (wraps at zero).
    // Only trusted while the core actually advanced this cycle.
    assign halt_target = bus.if_pc - PC_WIDTH'(1);
    assign halt_hit    = core_en_q && bus.id_is_jump && (bus.id_jump_addr == halt_target);

    // A launch from IDLE or HALTED restarts the performance count.
    assign cnt_clear = !bus.abort && bus.start &&
                       ((state == RC_IDLE) || (state == RC_HALTED));

    // Sequencer FSM with registered outputs; abort beats halt beats step/start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RC_IDLE;
            drain_cnt <= '0;
            core_en_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else if (bus.abort) begin
            state     <= RC_IDLE;
            drain_cnt <= '0;
            core_en_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                RC_IDLE, RC_HALTED: begin
                    if (bus.start) begin
                        state     <= RC_RUN;
                        core_en_q <= !bus.step_mode;
                        busy_q    <= 1'b1;
                        halted_q  <= 1'b0;
                    end else begin
                        core_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                RC_RUN: begin
                    if (halt_hit) begin
                        state     <= RC_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        core_en_q <= 1'b1;
                    end else begin
                        core_en_q <= bus.step_mode ? bus.step : 1'b1;
                    end
                end
                RC_DRAIN: begin
                    if (drain_cnt == DW'(1)) begin
                        state     <= RC_HALTED;
                        drain_cnt <= '0;
                        core_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        halted_q  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                        core_en_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= RC_IDLE;
                    drain_cnt <= '0;
                    core_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_en = core_en_q;
    assign bus.busy    = busy_q;
    assign bus.halted  = halted_q;

    lapido_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (core_en_q),
        .clear (cnt_clear),
        .count (bus.cycle_count)
    );

endmodule

// File: doc/lapido_run_ctrl.md
Name: lapido_run_ctrl

Overview:
- Execution sequencer for the lapido_top core.
- Gates the core clock-enable: free-run or single-step.
- Detects the halt idiom: a jump in ID whose target equals IF_pc-1, i.e. a jump-to-self.
- Drains the pipeline for a fixed number of cycles, then parks the core and flags halted. It also counts enabled cycles for performance reporting, replacing ad hoc halt logic in benches.

Parameters:
- PC_WIDTH, 32, width of program counter and jump address.
- CNT_WIDTH, 32, width of the enabled-cycle counter.
- DRAIN_CYCLES, 3, cycles core_en stays high after halt detection (min 1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; begin execution.
- abort  in  1  one-cycle pulse; force IDLE from any state.
- step_mode  in  1  1 = single-step, 0 = free-run; sampled each cycle.
- step  in  1  one-cycle pulse; advance one core cycle in step mode.
- id_is_jump  in  1  ID stage holds a jump.
- id_jump_addr  in  PC_WIDTH  jump target decoded in ID.
- if_pc  in  PC_WIDTH  current IF program counter.
- core_en  out  1  core advance enable (registered).
- busy  out  1  state is RUN or DRAIN (registered).
- halted  out  1  state is HALTED (registered).
- cycle_count  out  CNT_WIDTH  cycles with core_en=1 since last start.

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED. All outputs are registered.
- Reset (rst=0, async): state=IDLE, core_en=0, busy=0, halted=0, cycle_count=0, drain counter=0. Reset mid-operation aborts immediately, with no drain.
- Halt condition: id_is_jump=1 and id_jump_addr == (if_pc - 1) mod 2^PC_WIDTH. For if_pc=0 the compare value is all-ones.
  - Evaluated only on edges where core_en=1. Ignored when core_en=0, since ID/IF contents are stale.
- Priority at each edge: abort > halt detection > step/start.
- IDLE:
  - start=1 at edge k -> RUN; cycle_count cleared to 0; busy=1 from cycle k+1.
  - core_en=1 from cycle k+1 if step_mode=0, else 0.
- RUN, step_mode=0: core_en=1 every cycle.
- RUN, step_mode=1: core_en=1 for exactly the one cycle following each edge where step=1, else 0.
  - A step held high for N cycles gives N enabled cycles.
  - Switching step_mode takes effect at the next edge.
- RUN, halt detected at edge m -> DRAIN, drain counter loaded with DRAIN_CYCLES.
  - core_en=1 for the DRAIN_CYCLES cycles following edge m, regardless of step_mode or step.
  - The counter decrements each edge. At the edge where it equals 1 -> HALTED.
- HALTED: core_en=0, busy=0, halted=1.
  - start=1 -> RUN, halted=0, cycle_count cleared, as from IDLE.
- start is ignored in RUN and DRAIN. Halt detection is ignored in DRAIN; no re-arm.
- abort=1 in any state -> IDLE next edge: core_en=0, busy=0, halted=0. cycle_count holds its value.
- cycle_count increments on every edge where core_en=1 (the cycle just completed). It saturates at 2^CNT_WIDTH-1 with no wrap.
- Simultaneous halt and step in step mode: halt wins, drain proceeds automatically.

Decomposition:
- lapido_defs.v gains:
  - state encodings `RC_IDLE=2'd0, `RC_RUN=2'd1, `RC_DRAIN=2'd2, `RC_HALTED=2'd3;
  - `PC_WIDTH reuse;
  - default DRAIN_CYCLES.
- One sub-module: lapido_sat_counter (enable, sync clear, saturating, async active-low reset), instantiated for cycle_count.
- FSM and drain counter stay inline.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then 1, no start for 10 cycles -> core_en=busy=halted=0, cycle_count=0 throughout.
- Free-run halt: start at cycle 0, jump with id_jump_addr=0x10, if_pc=0x11 at cycle 20 -> core_en high cycles 1..23, halted=1 from cycle 24, cycle_count=23.
- Near-miss and wrap: id_jump_addr=0x10, if_pc=0x12 -> no halt. if_pc=0, id_jump_addr=0xFFFFFFFF, id_is_jump=1 -> DRAIN entered.
- Step mode: step_mode=1, three step pulses spaced 4 cycles apart -> exactly 3 single-cycle core_en pulses, cycle_count=3. A halt on the third pulse -> 3 further enabled cycles, then halted=1, cycle_count=6.
- Abort/reset in DRAIN: abort on the first DRAIN cycle -> IDLE next edge, core_en=0, halted never set. Repeat with rst=0 mid-DRAIN -> outputs cleared asynchronously.
- Restart and saturation: start in HALTED -> RUN, cycle_count restarts from 0. With CNT_WIDTH=4, 20 free-run cycles -> cycle_count holds at 15.
